universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
Parametrised WIDTH-bit register built from D-type storage. It performs one of eight operations per enabled rising clock edge: hold, logical shifts, arithmetic shift, rotates, parallel load and clear. It replaces ad-hoc single flip-flops in datapaths that need serial/parallel conversion or bit rotation. Serial in/out pins allow several instances to be chained into wider registers.

Parameters:
WIDTH, 8, register width in bits; legal range is 1 or more.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on asynchronous reset.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset; forces q to RESET_VALUE immediately
en  input  1  operation enable; when low, q holds regardless of mode
mode  input  3  operation select (encoding below)
d  input  WIDTH  parallel load data
sin_l  input  1  serial input entering at the MSB on logical shift right
sin_r  input  1  serial input entering at the LSB on shift left
q  output  WIDTH  registered register contents
sout_l  output  1  combinational q[WIDTH-1]; the bit shifted out on shift left
sout_r  output  1  combinational q[0]; the bit shifted out on shift right
zero  output  1  combinational flag, high when q == 0

Behaviour:
- Reset: rst high clears state asynchronously, without waiting for clk. While rst is high, q = RESET_VALUE, sout_l = RESET_VALUE[WIDTH-1], sout_r = RESET_VALUE[0], and zero = (RESET_VALUE == 0).
- Reset has priority over en and mode. The first update after rst deasserts happens on the next rising clk edge.
- Latency: one cycle. The result of the op sampled at edge N is visible on q after edge N, so sout_l, sout_r and zero also reflect it after edge N.
- When en = 0, q holds. Otherwise, on each rising edge:
  - 000 HOLD: q unchanged.
  - 001 SHL: q = {q[WIDTH-2:0], sin_r}.
  - 010 SHR (logical): q = {sin_l, q[WIDTH-1:1]}.
  - 011 ASR: q = {q[WIDTH-1], q[WIDTH-1:1]}; sin_l is ignored.
  - 100 ROL: q = {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q = {q[0], q[WIDTH-1:1]}.
  - 110 LOAD: q = d.
  - 111 CLR: q = 0. This is a synchronous clear to 0, not to RESET_VALUE.
- Inputs sampled: d, sin_l, sin_r, en and mode are sampled only at the rising edge. Glitches between edges have no effect.
- WIDTH = 1 boundary:
  - SHL loads sin_r.
  - SHR loads sin_l.
  - ASR, ROL and ROR hold.
  - The implementation must elaborate without zero-width part-selects.
- Chaining: sout_l of a lower instance drives sin_r of the upper instance; sout_r of the upper instance drives sin_l of the lower one. Shifts propagate correctly in the same edge because the serial outputs are derived from pre-edge q.
- Only one write source exists, so there are no simultaneous-event conflicts beyond reset priority. X on mode while en = 1 is a verification error; RTL may treat undefined values as HOLD.

Decomposition:
- Shared package usr_pkg holds:
  - localparams for the 3-bit mode encodings: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROL, MODE_ROR, MODE_LOAD, MODE_CLR;
  - the MODE_W = 3 width constant.
- One natural sub-module is usr_bit_cell: a per-bit 8:1 next-state mux feeding a DFF with async-high reset and per-bit reset value.
- The top generates WIDTH cells. It wires neighbour taps, with explicit handling at bit 0 and bit WIDTH-1.

Test Plan:
1. WIDTH=8, RESET_VALUE=8'hA5. Assert rst mid-cycle → q = A5 before the next clk edge; zero = 0, sout_l = 1, sout_r = 1.
2. LOAD d=8'h81, then SHL with sin_r=0 twice → q = 02 then 04; sout_l = 1 after LOAD and 0 after the first SHL.
3. LOAD 8'h90, then ASR ×2 → q = C8 then E4. Then SHR with sin_l=0 → q = 72.
4. LOAD 8'h81, then ROL → 03 and ROR → 81. With en=0 and mode=ROL for 3 cycles → q stays 81.
5. LOAD 8'h3C then CLR → q = 00 and zero = 1. Assert rst during a SHL cycle → q = RESET_VALUE immediately, with no shift applied on that edge.
6. Two chained WIDTH=4 instances form 8 bits, loaded with 8'hF0. SHL with sin_r=1 → combined value E1. WIDTH=1 instance with SHL and sin_r=1 → q = 1; ROL → q holds.

Source files
------------

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
//   Shared constants for the universal shift register:
//     MODE_W       width of the operation-select field
//     MODE_*       3-bit operation encodings driven on the 'mode' port
// -----------------------------------------------------------------------------
package usr_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
    localparam logic [MODE_W-1:0] MODE_ASR  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

endpackage : usr_pkg

// File: rtl/usr_bit_cell.sv
// -----------------------------------------------------------------------------
// usr_bit_cell
//   One bit of the universal shift register: an 8:1 next-state mux in front of
//   a D flip-flop with asynchronous active-high reset to RESET_BIT.
//   The parent supplies the neighbour taps, so every bit position uses the
//   same cell and all edge-of-register handling lives in the top.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset, loads RESET_BIT
//   en       update enable; when low the bit holds
//   mode     operation select (usr_pkg::MODE_*)
//   d        parallel-load bit
//   shl_tap  value entering this bit on SHL (lower neighbour or sin_r)
//   shr_tap  value entering this bit on SHR (upper neighbour or sin_l)
//   asr_tap  value entering this bit on ASR (upper neighbour or own MSB)
//   rol_tap  value entering this bit on ROL (lower neighbour or MSB)
//   ror_tap  value entering this bit on ROR (upper neighbour or LSB)
//   q        registered bit
// -----------------------------------------------------------------------------
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic              d,
    input  logic              shl_tap,
    input  logic              shr_tap,
    input  logic              asr_tap,
    input  logic              rol_tap,
    input  logic              ror_tap,
    output logic              q
);

    logic next;

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // 'next' unassigned, which would otherwise infer a latch.
        next = q;
        case (mode)
            MODE_HOLD: next = q;
            MODE_SHL:  next = shl_tap;
            MODE_SHR:  next = shr_tap;
            MODE_ASR:  next = asr_tap;
            MODE_ROL:  next = rol_tap;
            MODE_ROR:  next = ror_tap;
            MODE_LOAD: next = d;
            MODE_CLR:  next = 1'b0;
            default:   next = q;    // undefined select behaves as HOLD
        endcase
    end

    // NOTE: non-blocking assignment so every cell samples its neighbours'
    // pre-edge values; blocking here would let a shift ripple through bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (en) begin
            q <= next;
        end
    end

endmodule : usr_bit_cell

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//   WIDTH-bit register performing HOLD, SHL, SHR, ASR, ROL, ROR, LOAD or CLR
//   on each enabled rising clock edge. Serial pins allow chaining instances:
//   lower.sout_l -> upper.sin_r and upper.sout_r -> lower.sin_l.
//
// Parameters:
//   WIDTH        register width (>= 1)
//   RESET_VALUE  value forced onto q by asynchronous reset
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   en      operation enable
//   mode    operation select (usr_pkg::MODE_*)
//   d       parallel load data
//   sin_l   serial input entering at the MSB on SHR
//   sin_r   serial input entering at the LSB on SHL
//   q       registered contents
//   sout_l  q[WIDTH-1], the bit leaving on SHL
//   sout_r  q[0], the bit leaving on SHR
//   zero    high when q is all zeros
// -----------------------------------------------------------------------------
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q,
    output logic              sout_l,
    output logic              sout_r,
    output logic              zero
);

    // Each bit picks its taps from neighbours; the two ends are wired to the
    // serial pins or wrap around. Only single-bit selects are used, so a
    // one-bit register elaborates cleanly: every tap collapses to q[0] except
    // the serial inputs, which gives the required hold behaviour for
    // ASR/ROL/ROR at WIDTH = 1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shl_tap;
        logic rol_tap;
        logic shr_tap;
        logic asr_tap;
        logic ror_tap;

        if (i == 0) begin : g_lsb
            assign shl_tap = sin_r;
            assign rol_tap = q[WIDTH-1];
        end else begin : g_lower
            assign shl_tap = q[i-1];
            assign rol_tap = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign shr_tap = sin_l;
            assign asr_tap = q[WIDTH-1];   // sign bit replicates
            assign ror_tap = q[0];
        end else begin : g_upper
            assign shr_tap = q[i+1];
            assign asr_tap = q[i+1];
            assign ror_tap = q[i+1];
        end

        usr_bit_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .mode    (mode),
            .d       (d[i]),
            .shl_tap (shl_tap),
            .shr_tap (shr_tap),
            .asr_tap (asr_tap),
            .rol_tap (rol_tap),
            .ror_tap (ror_tap),
            .q       (q[i])
        );
    end

    // Serial outputs come from the pre-edge register so chained instances
    // shift coherently on the same edge.
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);

endmodule : universal_shift_register
